hlsm_stim_checker: RTL and testbench
====================================

HLSM_STIM_CHECKER -- requirements
Module: hlsm_stim_checker

Interface
REQ-001 Parameter DATAWIDTH, default 16: bit width of each operand and each result; legal range 1..32.
REQ-002 Parameter NUM_IN, default 5: number of operands driven to the DUT and the reference model.
REQ-003 Parameter NUM_OUT, default 1: number of result channels compared.
REQ-004 Parameter NUM_TESTS, default 256: number of Start/Done transactions per run; legal range 1..65535.
REQ-005 Parameter TIMEOUT, default 64: cycles WAIT may last before a timeout error; legal range 1..65535.
REQ-006 Parameter SEED, default 32'hACE1_0001: nonzero base seed for the operand LFSRs.
REQ-007 Port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-008 Port Rst, input, 1: asynchronous, active-high reset.
REQ-009 Port Run, input, 1: level-sensitive enable; starts a run and holds the result.
REQ-010 Port Start, output, 1: one-cycle launch pulse to the DUT and the reference model.
REQ-011 Port Operands, output, NUM_IN*DATAWIDTH: operand k occupies bits [k*DATAWIDTH +: DATAWIDTH].
REQ-012 Port Done / DoneRef, input, 1 each: completion flags from the DUT and the reference model.
REQ-013 Port Result / ResultRef, input, NUM_OUT*DATAWIDTH each: packed the same way as Operands.
REQ-014 Port Err, output, 1: registered one-cycle pulse on any detected mismatch.
REQ-015 Port ErrCnt, output, 16: saturating count of errors.
REQ-016 Port TestCnt, output, 16: number of completed transactions.
REQ-017 Port Finished, output, 1: run complete.
REQ-018 Port TimeoutErr, output, 1: sticky timeout flag.

Function
REQ-019 The block SHALL implement states IDLE, LAUNCH, WAIT and FINISH.
REQ-020 IDLE SHALL move to LAUNCH when Run=1.
REQ-021 LAUNCH SHALL assert Start for exactly one cycle, advance every LFSR once and register the new Operands in the same cycle, then move to WAIT.
REQ-022 Operand k SHALL come from its own 32-bit Galois LFSR (taps 32,22,2,1), seeded with SEED+k; the operand is the LFSR's low DATAWIDTH bits.
REQ-023 Operands SHALL remain stable from LAUNCH until the next LAUNCH.
REQ-024 In WAIT, any cycle with Done XOR DoneRef SHALL pulse Err on the next cycle and increment ErrCnt by 1.
REQ-025 In WAIT, when Done=1, every channel with a bitwise difference between Result and ResultRef SHALL count as one error; ErrCnt SHALL increase by the number of mismatching channels, and Err SHALL pulse on the next cycle.
REQ-026 A Done XOR DoneRef mismatch and data mismatches detected in the same cycle SHALL all be added to ErrCnt.
REQ-027 When Done=1 in WAIT, TestCnt SHALL increment; the state SHALL then move to LAUNCH if TestCnt+1 < NUM_TESTS, otherwise to FINISH.
REQ-028 Done or DoneRef asserted outside WAIT SHALL be ignored.
REQ-029 ErrCnt SHALL saturate at 16'hFFFF and never wrap.
REQ-030 FINISH SHALL hold Finished=1 and all counters stable while Run=1.
REQ-031 FINISH SHALL return to IDLE when Run=0; leaving FINISH SHALL clear Finished.
REQ-032 Counters SHALL clear on the IDLE-to-LAUNCH transition.
REQ-033 Run dropping in LAUNCH or WAIT SHALL NOT abort the transaction in progress; the run SHALL complete as normal.

Reset
REQ-034 Rst=1 SHALL immediately force: state IDLE, Start=0, Operands=0, Err=0, ErrCnt=0, TestCnt=0, Finished=0, TimeoutErr=0, and every LFSR to its seed.
REQ-035 Reset SHALL take effect mid-transaction with no further Start pulse.
REQ-036 After reset release, the block SHALL wait in IDLE until Run=1.

Configuration
REQ-037 Macro HLSM_CHK_TIMEOUT_EN SHALL control the timeout watchdog.
REQ-038 With HLSM_CHK_TIMEOUT_EN defined, a WAIT cycle counter SHALL run; if it reaches TIMEOUT with Done never seen, then:
- TimeoutErr SHALL set (sticky until reset or a new run);
- Err SHALL pulse;
- ErrCnt SHALL increment;
- the state SHALL move to FINISH.
REQ-039 Without HLSM_CHK_TIMEOUT_EN, there SHALL be no watchdog counter, TimeoutErr SHALL be tied to 0, and WAIT SHALL last indefinitely.

Verification
REQ-040 Matching 4-cycle reference model, NUM_TESTS=8, Run=1 -> 8 Start pulses, TestCnt=8, ErrCnt=0, Finished=1.
REQ-041 DUT Result forced to ResultRef^16'h0001 on every transaction, NUM_TESTS=4 -> ErrCnt=4 and Err pulses 4 times.
REQ-042 DUT Done one cycle later than DoneRef on test 0 -> two Done XOR DoneRef errors (the DoneRef-only cycle and the Done-only cycle), ErrCnt=2, TestCnt advances once.
REQ-043 HLSM_CHK_TIMEOUT_EN defined, TIMEOUT=10, Done tied to 0 -> TimeoutErr=1, ErrCnt=1 after 10 WAIT cycles, Finished=1.
REQ-044 Rst pulsed during WAIT of test 3 -> all outputs 0; the next run reproduces the Operands of test 0 (seed restart).
REQ-045 ErrCnt preloaded near saturation by forcing mismatches with NUM_OUT=4 -> ErrCnt holds at 16'hFFFF.

Source files
------------

// File: rtl/hlsm_stim_checker.sv
// Stimulus generator and result checker for an HLS-style Start/Done datapath.
// Optional watchdog on the WAIT state is enabled by defining HLSM_CHK_TIMEOUT_EN.
`timescale 1ns/1ps
module hlsm_stim_checker #(
  parameter int unsigned DATAWIDTH = 16,
  parameter int unsigned NUM_IN    = 5,
  parameter int unsigned NUM_OUT   = 1,
  parameter int unsigned NUM_TESTS = 256,
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] SEED      = 32'hACE1_0001
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Run,
  output logic                         Start,
  output logic [NUM_IN*DATAWIDTH-1:0]  Operands,
  input  logic                         Done,
  input  logic                         DoneRef,
  input  logic [NUM_OUT*DATAWIDTH-1:0] Result,
  input  logic [NUM_OUT*DATAWIDTH-1:0] ResultRef,
  output logic                         Err,
  output logic [15:0]                  ErrCnt,
  output logic [15:0]                  TestCnt,
  output logic                         Finished,
  output logic                         TimeoutErr
);

  if (DATAWIDTH < 1 || DATAWIDTH > 32) begin : g_bad_datawidth
    $error("hlsm_stim_checker: DATAWIDTH must be 1..32");
  end
  if (NUM_TESTS < 1 || NUM_TESTS > 65535) begin : g_bad_num_tests
    $error("hlsm_stim_checker: NUM_TESTS must be 1..65535");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("hlsm_stim_checker: TIMEOUT must be 1..65535");
  end
  if (SEED == 32'd0) begin : g_bad_seed
    $error("hlsm_stim_checker: SEED must be nonzero");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FINISH
  } state_t;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] NT        = 32'(NUM_TESTS);

  state_t      state, state_nxt;
  logic        clr;
  logic        advance;
  logic        tmo;
  logic [31:0] lfsr     [NUM_IN];
  logic [31:0] lfsr_nxt [NUM_IN];
  logic [31:0] mism;
  logic [31:0] err_add;
  logic [31:0] err_sum;
  logic [31:0] tests_next;

  assign Start    = (state == ST_LAUNCH);
  assign Finished = (state == ST_FINISH);

  always_comb begin
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      lfsr_nxt[k] = {1'b0, lfsr[k][31:1]} ^ (lfsr[k][0] ? LFSR_MASK : 32'd0);
    end
  end

  assign tests_next = {16'd0, TestCnt} + 32'd1;

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Run) begin
          state_nxt = ST_LAUNCH;
          clr       = 1'b1;
        end
      end
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (Done) begin
          state_nxt = (tests_next < NT) ? ST_LAUNCH : ST_FINISH;
        end else if (tmo) begin
          state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (!Run) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    advance = (state_nxt == ST_LAUNCH);
  end

  // Done/DoneRef disagreement, per-channel data mismatches and a timeout
  // occurring in one cycle are all summed into a single increment.
  always_comb begin
    mism = '0;
    for (int unsigned j = 0; j < NUM_OUT; j++) begin
      if (Result[j*DATAWIDTH +: DATAWIDTH] != ResultRef[j*DATAWIDTH +: DATAWIDTH]) begin
        mism = mism + 32'd1;
      end
    end
    err_add = '0;
    if (state == ST_WAIT) begin
      err_add = 32'(Done ^ DoneRef) + (Done ? mism : 32'd0) + 32'(tmo);
    end
    err_sum = {16'd0, ErrCnt} + err_add;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      Operands <= '0;
      Err      <= 1'b0;
      ErrCnt   <= '0;
      TestCnt  <= '0;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        lfsr[k] <= SEED + 32'(k);
      end
    end else begin
      state <= state_nxt;
      Err   <= (err_add != 32'd0);
      if (clr) begin
        ErrCnt  <= '0;
        TestCnt <= '0;
      end else begin
        if (err_add != 32'd0) begin
          ErrCnt <= (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
        end
        if (state == ST_WAIT && Done) begin
          TestCnt <= tests_next[15:0];
        end
      end
      if (advance) begin
        for (int unsigned k = 0; k < NUM_IN; k++) begin
          lfsr[k]                              <= lfsr_nxt[k];
          Operands[k*DATAWIDTH +: DATAWIDTH]   <= lfsr_nxt[k][DATAWIDTH-1:0];
        end
      end
    end
  end

`ifdef HLSM_CHK_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wd;

  assign tmo = (state == ST_WAIT) && !Done && (wd == TMO_LAST);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wd         <= '0;
      TimeoutErr <= 1'b0;
    end else begin
      if (state == ST_WAIT) wd <= wd + 16'd1;
      else                  wd <= '0;
      if (clr)      TimeoutErr <= 1'b0;
      else if (tmo) TimeoutErr <= 1'b1;
    end
  end
`else
  assign tmo        = 1'b0;
  assign TimeoutErr = 1'b0;
`endif

endmodule

// File: tb/tb_hlsm_stim_checker.sv
// Scoreboarded bench: expected operand vectors are queued from an LFSR model
// and compared when Start fires; tasks play both the DUT and reference model.
`timescale 1ns/1ps
module tb_hlsm_stim_checker;
  localparam int DW = 16;
  localparam int NI = 5;
  localparam int NO = 4;
  localparam int NT = 8;
  localparam int TO = 10;

  logic              Clk = 1'b0;
  logic              Rst, Run, Start, Done, DoneRef, Err, Finished, TimeoutErr;
  logic [NI*DW-1:0]  Operands;
  logic [NO*DW-1:0]  Result, ResultRef;
  logic [15:0]       ErrCnt, TestCnt;

  logic              s_run, s_start, s_done, s_doneref, s_err, s_finished, s_tmo;
  logic [NI*DW-1:0]  s_ops;
  logic [NO*DW-1:0]  s_result, s_resultref;
  logic [15:0]       s_errcnt, s_testcnt;

  int errors = 0;
  int checks = 0;
  int start_pulses = 0;
  int err_pulses = 0;

  logic [31:0]      mdl [NI];
  logic [NI*DW-1:0] exp_q [$];

  hlsm_stim_checker #(
    .DATAWIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .NUM_TESTS(NT), .TIMEOUT(TO),
    .SEED(32'hACE1_0001)
  ) u_main (
    .Clk(Clk), .Rst(Rst), .Run(Run), .Start(Start), .Operands(Operands),
    .Done(Done), .DoneRef(DoneRef), .Result(Result), .ResultRef(ResultRef),
    .Err(Err), .ErrCnt(ErrCnt), .TestCnt(TestCnt), .Finished(Finished),
    .TimeoutErr(TimeoutErr)
  );

  hlsm_stim_checker #(
    .DATAWIDTH(DW), .NUM_IN(NI), .NUM_OUT(NO), .NUM_TESTS(20000), .TIMEOUT(64),
    .SEED(32'hACE1_0001)
  ) u_sat (
    .Clk(Clk), .Rst(Rst), .Run(s_run), .Start(s_start), .Operands(s_ops),
    .Done(s_done), .DoneRef(s_doneref), .Result(s_result), .ResultRef(s_resultref),
    .Err(s_err), .ErrCnt(s_errcnt), .TestCnt(s_testcnt), .Finished(s_finished),
    .TimeoutErr(s_tmo)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (Start) start_pulses++;
    if (Err)   err_pulses++;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic model_reseed();
    for (int k = 0; k < NI; k++) mdl[k] = 32'hACE1_0001 + 32'(k);
    exp_q.delete();
  endtask

  task automatic push_expected();
    logic [NI*DW-1:0] v;
    for (int k = 0; k < NI; k++) begin
      mdl[k] = lfsr_step(mdl[k]);
      v[k*DW +: DW] = mdl[k][DW-1:0];
    end
    exp_q.push_back(v);
  endtask

  // One transaction: wait for Start, then raise DoneRef at cycle lr and Done at
  // cycle ld (ld=0 means Done never comes; returns two cycles after Start).
  task automatic serve(input int lr, input int ld, input logic [NO*DW-1:0] xr);
    logic [NI*DW-1:0] expv, ops;
    logic [NO*DW-1:0] ref_v;
    bit got = 0;
    int mx;
    push_expected();
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clk);
      Done = 1'b0; DoneRef = 1'b0;
      if (Start) got = 1;
    end
    expv = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL start_wait: Start=%0b required 1 within 40 cycles", Start);
      return;
    end
    ops = Operands;
    checks++;
    if (ops !== expv) begin
      errors++;
      $display("FAIL operands: got %h required %h", ops, expv);
    end
    for (int j = 0; j < NO; j++) ref_v[j*DW +: DW] = ops[j*DW +: DW] + ops[(j+1)*DW +: DW];
    ResultRef = ref_v;
    Result    = ref_v ^ xr;
    mx = (ld > 0) ? ld : 2;
    for (int c = 1; c <= mx; c++) begin
      @(negedge Clk);
      if (c == 1) begin
        checks++;
        if (Start !== 1'b0) begin
          errors++;
          $display("FAIL start_width: Start=%0b required 0 one cycle after launch", Start);
        end
      end
      DoneRef = (c == lr);
      Done    = (c == ld);
    end
    checks++;
    if (Operands !== ops) begin
      errors++;
      $display("FAIL operand_hold: got %h required %h", Operands, ops);
    end
  endtask

  task automatic wait_finished();
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      Done = 1'b0; DoneRef = 1'b0;
      if (Finished) got = 1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL finished_wait: Finished=%0b required 1 within 20 cycles", Finished);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; Run = 1'b0; Done = 1'b0; DoneRef = 1'b0;
    Result = '0; ResultRef = '0;
    s_run = 1'b0; s_done = 1'b0; s_doneref = 1'b0; s_result = '0; s_resultref = '0;
    repeat (2) @(negedge Clk);
    checks++;
    if ({Start, Err, Finished, TimeoutErr} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", {Start, Err, Finished, TimeoutErr});
    end
    checks++;
    if (Operands !== '0) begin
      errors++;
      $display("FAIL reset_operands: got %h required 0", Operands);
    end
    checks++;
    if ({ErrCnt, TestCnt} !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts: got %h required 0", {ErrCnt, TestCnt});
    end
    Rst = 1'b0;
    model_reseed();
    Done = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({Start, Err, ErrCnt} !== 18'h0) begin
      errors++;
      $display("FAIL idle_ignore: Start/Err/ErrCnt=%h required 0", {Start, Err, ErrCnt});
    end
    Done = 1'b0;
  endtask

  task automatic test_clean_run();
    start_pulses = 0; err_pulses = 0;
    Run = 1'b1;
    for (int t = 0; t < NT; t++) serve(4, 4, '0);
    wait_finished();
    checks++;
    if (TestCnt !== 16'd8 || ErrCnt !== 16'd0) begin
      errors++;
      $display("FAIL clean_counts: TestCnt=%0d ErrCnt=%0d required 8 and 0", TestCnt, ErrCnt);
    end
    checks++;
    if (start_pulses != 8 || err_pulses != 0) begin
      errors++;
      $display("FAIL clean_pulses: starts=%0d errs=%0d required 8 and 0", start_pulses, err_pulses);
    end
    repeat (3) @(negedge Clk);
    checks++;
    if (Finished !== 1'b1 || TestCnt !== 16'd8 || ErrCnt !== 16'd0 || TimeoutErr !== 1'b0) begin
      errors++;
      $display("FAIL finish_hold: Finished=%0b TestCnt=%0d ErrCnt=%0d Tmo=%0b required 1/8/0/0",
               Finished, TestCnt, ErrCnt, TimeoutErr);
    end
    Run = 1'b0;
    @(negedge Clk);
    checks++;
    if (Finished !== 1'b0 || TestCnt !== 16'd8) begin
      errors++;
      $display("FAIL finish_exit: Finished=%0b TestCnt=%0d required 0 and 8", Finished, TestCnt);
    end
  endtask

  task automatic test_data_mismatch();
    err_pulses = 0;
    Run = 1'b1;
    for (int t = 0; t < NT; t++) begin
      serve(4, 4, (t == NT-1) ? {NO{16'h0001}} : 64'h0001);
      if (t == 0) begin
        checks++;
        if (TestCnt !== 16'd0 || ErrCnt !== 16'd0) begin
          errors++;
          $display("FAIL run_clear: TestCnt=%0d ErrCnt=%0d required 0 and 0", TestCnt, ErrCnt);
        end
      end
    end
    wait_finished();
    @(negedge Clk);
    checks++;
    if (ErrCnt !== 16'd11 || TestCnt !== 16'd8) begin
      errors++;
      $display("FAIL data_errcnt: ErrCnt=%0d TestCnt=%0d required 11 and 8", ErrCnt, TestCnt);
    end
    checks++;
    if (err_pulses != 8) begin
      errors++;
      $display("FAIL data_err_pulses: got %0d required 8", err_pulses);
    end
    Run = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_done_skew();
    err_pulses = 0;
    Run = 1'b1;
    serve(4, 5, '0);
    checks++;
    if (ErrCnt !== 16'd1 || TestCnt !== 16'd0) begin
      errors++;
      $display("FAIL skew_first: ErrCnt=%0d TestCnt=%0d required 1 and 0", ErrCnt, TestCnt);
    end
    Run = 1'b0;   // dropping Run must not abort the run
    serve(6, 4, 64'h0001);
    for (int t = 2; t < NT; t++) serve(4, 4, '0);
    wait_finished();
    checks++;
    if (ErrCnt !== 16'd4 || TestCnt !== 16'd8) begin
      errors++;
      $display("FAIL skew_counts: ErrCnt=%0d TestCnt=%0d required 4 and 8", ErrCnt, TestCnt);
    end
    @(negedge Clk);
    checks++;
    if (err_pulses != 3 || Finished !== 1'b0) begin
      errors++;
      $display("FAIL skew_pulses: errs=%0d Finished=%0b required 3 and 0", err_pulses, Finished);
    end
  endtask

  task automatic test_timeout();
    err_pulses = 0;
    Run = 1'b1;
    serve(0, 0, '0);
`ifdef HLSM_CHK_TIMEOUT_EN
    for (int c = 3; c <= 11; c++) begin
      @(negedge Clk);
      if (c == 10) begin
        checks++;
        if (Finished !== 1'b0) begin
          errors++;
          $display("FAIL timeout_early: Finished=%0b required 0 after 9 WAIT cycles", Finished);
        end
      end
      if (c == 11) begin
        checks++;
        if (Finished !== 1'b1 || TimeoutErr !== 1'b1) begin
          errors++;
          $display("FAIL timeout_fire: Finished=%0b Tmo=%0b required 1 and 1", Finished, TimeoutErr);
        end
      end
    end
    @(negedge Clk);
    checks++;
    if (ErrCnt !== 16'd1 || TestCnt !== 16'd0 || err_pulses != 1) begin
      errors++;
      $display("FAIL timeout_counts: ErrCnt=%0d TestCnt=%0d errs=%0d required 1/0/1",
               ErrCnt, TestCnt, err_pulses);
    end
    Run = 1'b0;
    @(negedge Clk);
    checks++;
    if (TimeoutErr !== 1'b1 || Finished !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: Tmo=%0b Finished=%0b required 1 and 0", TimeoutErr, Finished);
    end
`else
    repeat (40) @(negedge Clk);
    checks++;
    if ({Finished, TimeoutErr, Start, Err} !== 4'b0 || ErrCnt !== 16'd0) begin
      errors++;
      $display("FAIL wait_forever: Fin/Tmo/Start/Err=%b ErrCnt=%0d required 0000 and 0",
               {Finished, TimeoutErr, Start, Err}, ErrCnt);
    end
    Run = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    model_reseed();
    Run = 1'b1;
    for (int t = 0; t < 3; t++) serve(4, 4, '0);
    serve(0, 0, '0);
    #2 Rst = 1'b1;
    #1;
    checks++;
    if ({Start, Err, Finished, TimeoutErr, ErrCnt, TestCnt} !== 36'h0 || Operands !== '0) begin
      errors++;
      $display("FAIL reset_async: flags/counts=%h Operands=%h required 0",
               {Start, Err, Finished, TimeoutErr, ErrCnt, TestCnt}, Operands);
    end
    Run = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
    repeat (3) @(negedge Clk);
    checks++;
    if (Start !== 1'b0 || start_pulses < 0) begin
      errors++;
      $display("FAIL reset_idle: Start=%0b required 0 while Run=0", Start);
    end
    model_reseed();
    Run = 1'b1;
    serve(4, 4, '0);   // must reproduce the test-0 operands of a fresh seed
    #2 Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0; Run = 1'b0; Done = 1'b0; DoneRef = 1'b0;
  endtask

  task automatic test_saturate();
    logic [15:0] prev = 16'd0;
    bit wrapped = 0, reached = 0, midpoint_ok = 0, midpoint_seen = 0;
    s_done = 1'b1; s_doneref = 1'b0;
    s_resultref = '0;
    s_result = {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    s_run = 1'b1;
    for (int i = 0; i < 40000 && !reached; i++) begin
      @(negedge Clk);
      if (s_errcnt < prev) wrapped = 1;
      prev = s_errcnt;
      if (s_testcnt == 16'd100 && !midpoint_seen) begin
        midpoint_seen = 1;
        midpoint_ok = (s_errcnt == 16'd400);
      end
      if (s_errcnt == 16'hFFFF) reached = 1;
    end
    checks++;
    if (!midpoint_ok) begin
      errors++;
      $display("FAIL sat_rate: ErrCnt at TestCnt=100 wrong (seen=%0b), required 400", midpoint_seen);
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL sat_reach: ErrCnt=%h required FFFF within budget", s_errcnt);
    end
    repeat (20) begin
      @(negedge Clk);
      if (s_errcnt < prev) wrapped = 1;
      prev = s_errcnt;
    end
    checks++;
    if (wrapped || s_errcnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold: ErrCnt=%h wrapped=%0b required FFFF and 0", s_errcnt, wrapped);
    end
    s_run = 1'b0; s_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_data_mismatch();
    test_done_skew();
    test_timeout();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
